// File: rtl/status_register.sv
// NZCV flag register with in-flight flag-setter tracking, EXE->ID flag bypass,
// stale-flag stall generation and a saturating stall-cycle counter.
module status_register #(
  parameter int PIPE_DEPTH = 2,
  parameter int BYPASS     = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             id_s,
  input  logic [3:0]       id_cond,
  input  logic             exe_s_update,
  input  logic [3:0]       exe_flags,
  output logic [3:0]       status,
  output logic [3:0]       status_q,
  output logic             flag_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [PIPE_DEPTH-1:0] EXE_MASK = PIPE_DEPTH'(1) << (PIPE_DEPTH - 1);
  localparam logic                  BYP_EN   = (BYPASS != 0);

  logic [PIPE_DEPTH-1:0] pend;
  logic [PIPE_DEPTH-1:0] pend_nxt;
  logic                  needs_flags;
  logic                  older;
  logic                  only_exe;
  logic                  bypass_hit;

  // AL (1110) and the 1111 encoding are unconditional and never read flags.
  assign needs_flags = id_valid & (id_cond[3:1] != 3'b111);
  assign older       = |pend;
  // Bypass only resolves the dependency when the EXE slot is the sole producer.
  assign only_exe    = ~|(pend & ~EXE_MASK);
  assign bypass_hit  = BYP_EN & exe_s_update & pend[PIPE_DEPTH-1] & only_exe;
  assign flag_stall  = needs_flags & older & ~bypass_hit & ~flush;
  assign status      = (BYP_EN & exe_s_update) ? exe_flags : status_q;

  always_comb begin
    pend_nxt    = '0;
    pend_nxt[0] = id_valid & id_s & ~flag_stall;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      pend_nxt[k] = pend[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend      <= '0;
      status_q  <= 4'b0000;
      stall_cnt <= '0;
    end else if (!freeze) begin
      if (flush) begin
        pend <= '0;
      end else begin
        pend <= pend_nxt;
      end
      if (exe_s_update) begin
        status_q <= exe_flags;
      end
      if (flag_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_status_register.sv
// Directed bench: three configurations (bypass, no bypass, 2-bit counter) share
// stimulus; expected outputs are queued per cycle and checked by a negedge monitor.
module tb_status_register;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        id_valid;
  logic        id_s;
  logic [3:0]  id_cond;
  logic        exe_s_update;
  logic [3:0]  exe_flags;

  logic [3:0]  status_b, status_nb, status_sat;
  logic [3:0]  status_q_b, status_q_nb, status_q_sat;
  logic        stall_b, stall_nb, stall_sat;
  logic [15:0] cnt_b, cnt_nb;
  logic [1:0]  cnt_sat;

  // entry: {sel[1:0], status[3:0], status_q[3:0], flag_stall, stall_cnt[15:0]}
  logic [26:0] exp_q[$];
  int total;
  int bad;

  localparam logic [3:0] AL = 4'b1110;
  localparam logic [3:0] NV = 4'b1111;
  localparam logic [3:0] EQ = 4'b0000;
  localparam logic [3:0] NE = 4'b0001;

  status_register #(.PIPE_DEPTH(2), .BYPASS(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_s(id_s), .id_cond(id_cond), .exe_s_update(exe_s_update), .exe_flags(exe_flags),
    .status(status_b), .status_q(status_q_b), .flag_stall(stall_b), .stall_cnt(cnt_b)
  );

  status_register #(.PIPE_DEPTH(2), .BYPASS(0), .CNT_W(16)) dut_nb (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_s(id_s), .id_cond(id_cond), .exe_s_update(exe_s_update), .exe_flags(exe_flags),
    .status(status_nb), .status_q(status_q_nb), .flag_stall(stall_nb), .stall_cnt(cnt_nb)
  );

  status_register #(.PIPE_DEPTH(2), .BYPASS(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_s(id_s), .id_cond(id_cond), .exe_s_update(exe_s_update), .exe_flags(exe_flags),
    .status(status_sat), .status_q(status_q_sat), .flag_stall(stall_sat), .stall_cnt(cnt_sat)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic cyc(input logic v, input logic s, input logic [3:0] cond,
                     input logic upd, input logic [3:0] flags,
                     input logic fl, input logic frz);
    id_valid     = v;
    id_s         = s;
    id_cond      = cond;
    exe_s_update = upd;
    exe_flags    = flags;
    flush        = fl;
    freeze       = frz;
  endtask

  task automatic chk(input logic [3:0] st_byp, input logic [3:0] q,
                     input logic stl_byp, input logic stl_nb,
                     input logic [15:0] c_b, input logic [15:0] c_nb, input logic [15:0] c_sat);
    exp_q.push_back({2'd0, st_byp, q, stl_byp, c_b});
    exp_q.push_back({2'd1, q,      q, stl_nb,  c_nb});
    exp_q.push_back({2'd2, st_byp, q, stl_byp, c_sat});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  task automatic cmp(input string name, input int sel, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s dut%0d @%0t: act=%0h req=%0h", name, sel, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [26:0] e;
      logic [3:0]  a_st, a_q;
      logic        a_stl;
      logic [15:0] a_cnt;
      e = exp_q.pop_front();
      case (e[26:25])
        2'd0:    begin a_st = status_b;   a_q = status_q_b;   a_stl = stall_b;   a_cnt = cnt_b;  end
        2'd1:    begin a_st = status_nb;  a_q = status_q_nb;  a_stl = stall_nb;  a_cnt = cnt_nb; end
        default: begin a_st = status_sat; a_q = status_q_sat; a_stl = stall_sat; a_cnt = {14'd0, cnt_sat}; end
      endcase
      cmp("status",     int'(e[26:25]), int'(a_st),  int'(e[24:21]));
      cmp("status_q",   int'(e[26:25]), int'(a_q),   int'(e[20:17]));
      cmp("flag_stall", int'(e[26:25]), int'(a_stl), int'(e[16]));
      cmp("stall_cnt",  int'(e[26:25]), int'(a_cnt), int'(e[15:0]));
    end
  end

  // stimulus
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 1'b0);
      if (i < 2) next_cycle();
    end
    next_cycle();
    rst = 1'b1;

    // reset state
    cyc(0, 0, AL, 0, 4'h0, 0, 0); chk(4'h0, 4'h0, 0, 0, 0, 0, 0); next_cycle();

    // ADDS then BEQ back to back
    cyc(1, 1, AL, 0, 4'h0, 0, 0); chk(4'h0, 4'h0, 0, 0, 0, 0, 0); next_cycle();
    cyc(1, 0, EQ, 0, 4'h0, 0, 0); chk(4'h0, 4'h0, 1, 1, 0, 0, 0); next_cycle();
    cyc(1, 0, EQ, 1, 4'h4, 0, 0); chk(4'h4, 4'h0, 0, 1, 1, 1, 1); next_cycle();
    cyc(1, 0, EQ, 0, 4'h0, 0, 0); chk(4'h4, 4'h4, 0, 0, 1, 2, 1); next_cycle();

    // unconditional instructions never stall; two setters in flight
    cyc(1, 1, AL, 0, 4'h0, 0, 0); chk(4'h4, 4'h4, 0, 0, 1, 2, 1); next_cycle();
    cyc(1, 1, NV, 0, 4'h0, 0, 0); chk(4'h4, 4'h4, 0, 0, 1, 2, 1); next_cycle();
    cyc(1, 0, AL, 1, 4'h2, 0, 0); chk(4'h2, 4'h4, 0, 0, 1, 2, 1); next_cycle();
    cyc(1, 0, NE, 1, 4'h9, 0, 0); chk(4'h9, 4'h2, 0, 1, 1, 2, 1); next_cycle();
    cyc(0, 0, AL, 0, 4'h0, 0, 0); chk(4'h9, 4'h9, 0, 0, 1, 3, 1); next_cycle();

    // flush while a stall would be raised
    cyc(1, 1, AL, 0, 4'h0, 0, 0); chk(4'h9, 4'h9, 0, 0, 1, 3, 1); next_cycle();
    cyc(1, 0, EQ, 0, 4'h0, 1, 0); chk(4'h9, 4'h9, 0, 0, 1, 3, 1); next_cycle();
    cyc(1, 0, EQ, 0, 4'h0, 0, 0); chk(4'h9, 4'h9, 0, 0, 1, 3, 1); next_cycle();

    // freeze holds status_q, pend and counter
    cyc(1, 1, AL, 0, 4'h0, 0, 0); chk(4'h9, 4'h9, 0, 0, 1, 3, 1); next_cycle();
    cyc(1, 0, EQ, 1, 4'hF, 0, 1); chk(4'hF, 4'h9, 1, 1, 1, 3, 1); next_cycle();
    cyc(1, 0, EQ, 0, 4'h0, 0, 0); chk(4'h9, 4'h9, 1, 1, 1, 3, 1); next_cycle();
    cyc(1, 0, EQ, 1, 4'h3, 0, 0); chk(4'h3, 4'h9, 0, 1, 2, 4, 2); next_cycle();
    cyc(0, 0, AL, 0, 4'h0, 0, 0); chk(4'h3, 4'h3, 0, 0, 2, 5, 2); next_cycle();

    // five forced stalls saturate the 2-bit counter
    cyc(1, 1, AL, 0, 4'h0, 0, 0); chk(4'h3, 4'h3, 0, 0, 2, 5, 2); next_cycle();
    cyc(1, 0, EQ, 0, 4'h0, 0, 0); chk(4'h3, 4'h3, 1, 1, 2, 5, 2); next_cycle();
    cyc(1, 0, EQ, 0, 4'h0, 0, 0); chk(4'h3, 4'h3, 1, 1, 3, 6, 3); next_cycle();
    cyc(1, 1, AL, 0, 4'h0, 0, 0); chk(4'h3, 4'h3, 0, 0, 4, 7, 3); next_cycle();
    cyc(1, 0, EQ, 0, 4'h0, 0, 0); chk(4'h3, 4'h3, 1, 1, 4, 7, 3); next_cycle();
    cyc(1, 0, EQ, 0, 4'h0, 0, 0); chk(4'h3, 4'h3, 1, 1, 5, 8, 3); next_cycle();
    cyc(1, 1, AL, 0, 4'h0, 0, 0); chk(4'h3, 4'h3, 0, 0, 6, 9, 3); next_cycle();
    cyc(1, 0, EQ, 0, 4'h0, 0, 0); chk(4'h3, 4'h3, 1, 1, 6, 9, 3); next_cycle();
    cyc(0, 0, AL, 0, 4'h0, 0, 0); chk(4'h3, 4'h3, 0, 0, 7, 10, 3); next_cycle();

    // reset in the middle of a stall
    cyc(1, 1, AL, 0, 4'h0, 0, 0); chk(4'h3, 4'h3, 0, 0, 7, 10, 3); next_cycle();
    rst = 1'b0;
    cyc(1, 0, EQ, 0, 4'h0, 0, 0); chk(4'h3, 4'h3, 1, 1, 7, 10, 3); next_cycle();
    rst = 1'b1;
    cyc(1, 0, EQ, 0, 4'h0, 0, 0); chk(4'h0, 4'h0, 0, 0, 0, 0, 0); next_cycle();

    // conditional flag setter enters pend only once it stops stalling
    cyc(1, 1, AL, 0, 4'h0, 0, 0); chk(4'h0, 4'h0, 0, 0, 0, 0, 0); next_cycle();
    cyc(1, 1, EQ, 0, 4'h0, 0, 0); chk(4'h0, 4'h0, 1, 1, 0, 0, 0); next_cycle();
    cyc(1, 1, EQ, 0, 4'h0, 0, 0); chk(4'h0, 4'h0, 1, 1, 1, 1, 1); next_cycle();
    cyc(1, 1, EQ, 0, 4'h0, 0, 0); chk(4'h0, 4'h0, 0, 0, 2, 2, 2); next_cycle();
    cyc(1, 0, EQ, 0, 4'h0, 0, 0); chk(4'h0, 4'h0, 1, 1, 2, 2, 2); next_cycle();
    cyc(0, 0, AL, 0, 4'h0, 0, 0); chk(4'h0, 4'h0, 0, 0, 3, 3, 3); next_cycle();

    next_cycle();
    next_cycle();
    cmp("queue_drained", 0, exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
